// File: rtl/scan_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// scan_sequencer_pkg
//
// Shared definitions for the scan sequencer that drives the 3-bit select of a
// one-hot 3-to-8 decoder.
//   - mode_e    : stepping mode encodings (up, down, bounce, hold)
//   - state_e   : sequencer FSM states (IDLE, RUN)
//   - SEL_MAX   : highest select value
//   - advance() : computes the next select value, direction and whether the
//                 step lands on the one-shot terminal value
// -----------------------------------------------------------------------------
package scan_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [2:0] SEL_MAX = 3'd7;
  localparam logic [2:0] SEL_MIN = 3'd0;

  typedef struct packed {
    logic [2:0] sel;
    logic       dir_up;
    logic       terminal;
  } advance_t;

  // One step of the select sequence. The terminal flag tells the caller that,
  // in one-shot operation, this step ends the pass.
  function automatic advance_t advance(input mode_e mode, input logic [2:0] sel,
                                       input logic dir_up);
    advance_t r;
    r.sel      = sel;
    r.dir_up   = dir_up;
    r.terminal = 1'b0;
    case (mode)
      MODE_UP: begin
        r.sel      = sel + 3'd1;
        r.terminal = (r.sel == SEL_MAX);
      end
      MODE_DOWN: begin
        r.sel      = sel - 3'd1;
        r.terminal = (r.sel == SEL_MIN);
      end
      MODE_BOUNCE: begin
        // Reversal happens in the same step that leaves the endpoint, so each
        // endpoint is shown exactly once per turn.
        if (dir_up) begin
          if (sel == SEL_MAX) begin
            r.sel    = sel - 3'd1;
            r.dir_up = 1'b0;
          end else begin
            r.sel = sel + 3'd1;
          end
        end else begin
          if (sel == SEL_MIN) begin
            r.sel    = sel + 3'd1;
            r.dir_up = 1'b1;
          end else begin
            r.sel = sel - 3'd1;
          end
        end
        // Only arriving at 0 on the way down ends a bounce pass.
        r.terminal = !dir_up && (sel != SEL_MIN) && (r.sel == SEL_MIN);
      end
      default: begin
        // Hold: select is frozen, the first step completes the pass.
        r.terminal = 1'b1;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/scan_sequencer_tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
//
// Free-running modulo counter that produces a one-cycle tick every limit+1
// enabled cycles. The count wraps to zero on the cycle it equals the limit.
//
// Ports:
//   clk_i    in   clock, rising edge
//   rst_ni   in   asynchronous active-low reset (count -> 0)
//   clr_i    in   synchronous clear of the count (dominates enable)
//   en_i     in   count enable
//   limit_i  in   terminal count value
//   tick_o   out  high while enabled and count == limit
// -----------------------------------------------------------------------------
module tick_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic [PRESCALE_W-1:0] limit_i,
  output logic                  tick_o
);

  localparam logic [PRESCALE_W-1:0] CNT_ZERO = '0;
  localparam logic [PRESCALE_W-1:0] CNT_ONE  = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  logic [PRESCALE_W-1:0] cnt_q;
  logic [PRESCALE_W-1:0] cnt_d;
  logic                  at_limit;

  assign at_limit = (cnt_q == limit_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = CNT_ZERO;
    end else if (en_i) begin
      cnt_d = at_limit ? CNT_ZERO : (cnt_q + CNT_ONE);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The tick is consumed by a register stage in the sequencer, so the
  // combinational form keeps the step exactly on the limit cycle's edge.
  assign tick_o = en_i && !clr_i && at_limit;

endmodule

// File: rtl/scan_sequencer.sv
// -----------------------------------------------------------------------------
// scan_sequencer
//
// Start/stop controlled sequencer for the 3-bit select of a one-hot 3-to-8
// decoder. Steps up, down, ping-pong (bounce) or holds, every period+1 cycles,
// either free-running or for a single pass. All outputs are registered.
//
// Ports:
//   clk_i      in   system clock, rising edge
//   rst_ni     in   asynchronous active-low reset
//   start_i    in   1-cycle request to begin a sequence (IDLE only)
//   stop_i     in   1-cycle request to abort a sequence (RUN only, beats start)
//   mode_i     in   00 up, 01 down, 10 bounce, 11 hold
//   oneshot_i  in   1 = end after one pass, 0 = free-run
//   period_i   in   step every period_i+1 cycles
//   sel_o      out  decoder select (A=sel[2], B=sel[1], C=sel[0])
//   busy_o     out  high while running
//   step_o     out  1-cycle pulse coincident with each sel update
//   done_o     out  1-cycle pulse when a one-shot pass completes
// -----------------------------------------------------------------------------
module scan_sequencer
  import scan_sequencer_pkg::*;
#(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [1:0]            mode_i,
  input  logic                  oneshot_i,
  input  logic [PRESCALE_W-1:0] period_i,
  output logic [2:0]            sel_o,
  output logic                  busy_o,
  output logic                  step_o,
  output logic                  done_o
);

  state_e                state_q,   state_d;
  mode_e                 mode_q,    mode_d;
  logic                  oneshot_q, oneshot_d;
  logic [PRESCALE_W-1:0] period_q,  period_d;
  logic [2:0]            sel_q,     sel_d;
  logic                  dir_up_q,  dir_up_d;
  logic                  busy_q,    busy_d;
  logic                  step_q,    step_d;
  logic                  done_q,    done_d;

  logic                  presc_clr;
  logic                  presc_en;
  logic                  presc_tick;
  advance_t              adv;

  tick_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_tick_prescaler (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (presc_clr),
    .en_i    (presc_en),
    .limit_i (period_q),
    .tick_o  (presc_tick)
  );

  assign adv = advance(mode_q, sel_q, dir_up_q);

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    oneshot_d = oneshot_q;
    period_d  = period_q;
    sel_d     = sel_q;
    dir_up_d  = dir_up_q;
    busy_d    = busy_q;
    step_d    = 1'b0;
    done_d    = 1'b0;
    presc_clr = 1'b0;
    presc_en  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d   = RUN;
          busy_d    = 1'b1;
          mode_d    = mode_e'(mode_i);
          oneshot_d = oneshot_i;
          period_d  = period_i;
          dir_up_d  = 1'b1;
          presc_clr = 1'b1;
          case (mode_e'(mode_i))
            MODE_UP,
            MODE_BOUNCE: sel_d = SEL_MIN;
            MODE_DOWN:   sel_d = SEL_MAX;
            default:     sel_d = sel_q;
          endcase
        end
      end
      RUN: begin
        if (stop_i) begin
          // Abort takes priority over any step due on this edge.
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          presc_en = 1'b1;
          if (presc_tick) begin
            sel_d    = adv.sel;
            dir_up_d = adv.dir_up;
            step_d   = 1'b1;
            if (oneshot_q && adv.terminal) begin
              done_d  = 1'b1;
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      mode_q    <= MODE_UP;
      oneshot_q <= 1'b0;
      period_q  <= '0;
      sel_q     <= SEL_MIN;
      dir_up_q  <= 1'b1;
      busy_q    <= 1'b0;
      step_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      oneshot_q <= oneshot_d;
      period_q  <= period_d;
      sel_q     <= sel_d;
      dir_up_q  <= dir_up_d;
      busy_q    <= busy_d;
      step_q    <= step_d;
      done_q    <= done_d;
    end
  end

  assign sel_o  = sel_q;
  assign busy_o = busy_q;
  assign step_o = step_q;
  assign done_o = done_q;

endmodule
